// File: rtl/tensor_pkg.sv
// Shared types for the tensor operand loader: DMA set encoding, loader FSM states,
// default buffer dimension and the operand-set to buffer-slot mapping.
package tensor_pkg;

  typedef enum logic [1:0] {
    SET_A = 2'd0,
    SET_B = 2'd1,
    SET_X = 2'd2,
    SET_W = 2'd3
  } set_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } loader_state_e;

  localparam int unsigned DEFAULT_DIM = 4;

  // Buffer slot and ready-flag bit: A=0, B=1, W=2 (matches consume {W,B,A}).
  function automatic logic [1:0] set_slot(input set_e s);
    case (s)
      SET_B:   return 2'd1;
      SET_W:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/x_result_fifo.sv
// Synchronous result FIFO with full/empty status and registered read data.
// Simultaneous push/pop is always accepted; pushing into an empty FIFO while popping bypasses to rd_data.
module x_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             ovf_evt,
  output logic             udf_evt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop & ~empty;
  assign wr_en   = push & (~full | pop) & ~(empty & pop);
  assign ovf_evt = push & full & ~pop;
  assign udf_evt = pop & empty & ~push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (pop) begin
        if (!empty)    rd_data <= mem[rd_ptr];
        else if (push) rd_data <= push_data;
        else           rd_data <= '0;
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tensor_operand_loader.sv
// Captures the DMA read stream into A/B/W operand buffers and buffers core results for DMA write-back.
// Option: define LOADER_TRANSPOSE_B_EN to store set B transposed ([col][row]).
module tensor_operand_loader
  import tensor_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 8,
  parameter int unsigned DIM         = DEFAULT_DIM,
  parameter int unsigned XFIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tensor_wen,
  input  logic                   tensor_ren,
  input  logic [1:0]             set,
  input  logic [DATAWIDTH-1:0]   depth_in,
  input  logic [DATAWIDTH-1:0]   width_in,
  input  logic                   finished_transfer,
  input  logic [DATAWIDTH-1:0]   mem_rdata,
  output logic [DATAWIDTH-1:0]   mem_wdata,
  input  logic [1:0]             rd_set,
  input  logic [$clog2(DIM)-1:0] rd_row,
  input  logic [$clog2(DIM)-1:0] rd_col,
  output logic [DATAWIDTH-1:0]   rd_data,
  input  logic [2:0]             consume,
  input  logic                   x_push,
  input  logic [DATAWIDTH-1:0]   x_data,
  output logic                   a_ready,
  output logic                   b_ready,
  output logic                   w_ready,
  output logic                   x_full,
  output logic                   x_empty,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int unsigned IW = $clog2(DIM);
  localparam logic [DATAWIDTH-1:0] DIM_W = DATAWIDTH'(DIM);

  logic [DATAWIDTH-1:0] bufs [3][DIM][DIM];
  loader_state_e        state;
  set_e                 cur_set;
  logic [DATAWIDTH-1:0] depth_l, width_l, row, col;
  logic [2:0]           rdy, rdy_nxt;

  logic                 do_store, in_range, row_wrap;
  set_e                 st_set;
  logic [DATAWIDTH-1:0] st_row, st_col, st_depth, nxt_row, nxt_col;
  logic [IW-1:0]        wr_r, wr_c;
  logic                 fifo_ovf, fifo_udf;

  // The first element arrives on the IDLE->LOAD cycle, so it is stored at [0][0] with the incoming dims.
  always_comb begin
    do_store = 1'b0;
    st_set   = cur_set;
    st_row   = row;
    st_col   = col;
    st_depth = depth_l;
    if (state == IDLE && tensor_wen && set_e'(set) != SET_X) begin
      do_store = 1'b1;
      st_set   = set_e'(set);
      st_row   = '0;
      st_col   = '0;
      st_depth = (depth_in == '0) ? DATAWIDTH'(1) : depth_in;
    end else if (state == LOAD && tensor_wen) begin
      do_store = 1'b1;
    end
    in_range = (st_row < DIM_W) && (st_col < DIM_W);
    row_wrap = (st_col == st_depth - DATAWIDTH'(1));
    nxt_col  = row_wrap ? '0 : st_col + DATAWIDTH'(1);
    nxt_row  = row_wrap ? st_row + DATAWIDTH'(1) : st_row;
    wr_r     = st_row[IW-1:0];
    wr_c     = st_col[IW-1:0];
`ifdef LOADER_TRANSPOSE_B_EN
    if (st_set == SET_B) begin
      wr_r = st_col[IW-1:0];
      wr_c = st_row[IW-1:0];
    end
`endif
  end

  // COMMIT is applied last so it overrides a same-cycle consume.
  always_comb begin
    rdy_nxt = rdy & ~consume;
    if (state == IDLE && do_store) rdy_nxt[set_slot(st_set)] = 1'b0;
    if (state == COMMIT)           rdy_nxt[set_slot(cur_set)] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_set       <= SET_A;
      depth_l       <= '0;
      width_l       <= '0;
      row           <= '0;
      col           <= '0;
      rdy           <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int unsigned i = 0; i < 3; i++)
        for (int unsigned j = 0; j < DIM; j++)
          for (int unsigned k = 0; k < DIM; k++)
            bufs[i][j][k] <= '0;
    end else begin
      rdy           <= rdy_nxt;
      err_overflow  <= err_overflow | fifo_ovf | (do_store & ~in_range);
      err_underflow <= err_underflow | fifo_udf;
      if (do_store && in_range) bufs[set_slot(st_set)][wr_r][wr_c] <= mem_rdata;
      if (do_store) begin
        row <= nxt_row;
        col <= nxt_col;
      end
      case (state)
        IDLE: if (do_store) begin
          state   <= LOAD;
          cur_set <= st_set;
          depth_l <= st_depth;
          width_l <= width_in;
        end
        LOAD: if (finished_transfer) state <= COMMIT;
        COMMIT: begin
          row   <= '0;
          col   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (set_e'(rd_set))
      SET_A:   rd_data = bufs[0][rd_row][rd_col];
      SET_B:   rd_data = bufs[1][rd_row][rd_col];
      SET_W:   rd_data = bufs[2][rd_row][rd_col];
      default: rd_data = '0;
    endcase
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign w_ready = rdy[2];

  x_result_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (XFIFO_DEPTH)
  ) u_xfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (x_push),
    .push_data (x_data),
    .pop       (tensor_ren),
    .rd_data   (mem_wdata),
    .full      (x_full),
    .empty     (x_empty),
    .ovf_evt   (fifo_ovf),
    .udf_evt   (fifo_udf)
  );

endmodule

// File: tb/tb_tensor_operand_loader.sv
// Directed self-checking bench for tensor_operand_loader (default DIM=4, XFIFO_DEPTH=16).
module tb_tensor_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       tensor_wen, tensor_ren, finished_transfer, x_push;
  logic [1:0] set, rd_set;
  logic [7:0] depth_in, width_in, mem_rdata, mem_wdata, rd_data, x_data;
  logic [1:0] rd_row, rd_col;
  logic [2:0] consume;
  logic       a_ready, b_ready, w_ready, x_full, x_empty, err_overflow, err_underflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  tensor_operand_loader #(.DATAWIDTH(8), .DIM(4), .XFIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .tensor_wen(tensor_wen), .tensor_ren(tensor_ren), .set(set),
    .depth_in(depth_in), .width_in(width_in), .finished_transfer(finished_transfer),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .rd_set(rd_set), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .consume(consume), .x_push(x_push), .x_data(x_data),
    .a_ready(a_ready), .b_ready(b_ready), .w_ready(w_ready), .x_full(x_full),
    .x_empty(x_empty), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] s, input logic [1:0] r,
                        input logic [1:0] c, input logic [7:0] exp);
    rd_set = s; rd_row = r; rd_col = c;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic stream(input logic [1:0] s, input logic [7:0] d, input logic [7:0] w,
                        input logic [7:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tensor_wen = 1'b1; set = s; depth_in = d; width_in = w;
      mem_rdata = base + 8'(i);
      tick();
    end
    tensor_wen = 1'b0;
  endtask

  task automatic finish_xfer();
    finished_transfer = 1'b1;
    tick();
    finished_transfer = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; tensor_wen = 1'b0; tensor_ren = 1'b0; finished_transfer = 1'b0; x_push = 1'b0;
    set = 2'd0; rd_set = 2'd0; depth_in = 8'd0; width_in = 8'd0; mem_rdata = 8'd0;
    x_data = 8'd0; rd_row = 2'd0; rd_col = 2'd0; consume = 3'b000;
    do_reset();

    check("rst_a_ready", a_ready, 1'b0);
    check("rst_x_empty", x_empty, 1'b1);
    check("rst_x_full", x_full, 1'b0);
    check("rst_err_ovf", err_overflow, 1'b0);
    check("rst_mem_wdata", mem_wdata, 8'd0);

    // 1: A, depth 3, width 2, data 1..6
    stream(2'd0, 8'd3, 8'd2, 8'd1, 6);
    finish_xfer();
    check("t1_a_ready_early", a_ready, 1'b0);
    tick();
    check("t1_a_ready", a_ready, 1'b1);
    rd_chk("t1_a00", 2'd0, 2'd0, 2'd0, 8'd1);
    rd_chk("t1_a02", 2'd0, 2'd0, 2'd2, 8'd3);
    rd_chk("t1_a10", 2'd0, 2'd1, 2'd0, 8'd4);
    rd_chk("t1_a12", 2'd0, 2'd1, 2'd2, 8'd6);

    // 2: B 2x2, data 10..13
    stream(2'd1, 8'd2, 8'd2, 8'd10, 4);
    finish_xfer();
    tick();
`ifdef LOADER_TRANSPOSE_B_EN
    rd_chk("t2_b01", 2'd1, 2'd0, 2'd1, 8'd12);
`else
    rd_chk("t2_b01", 2'd1, 2'd0, 2'd1, 8'd11);
`endif
    rd_chk("t2_b11", 2'd1, 2'd1, 2'd1, 8'd13);
    check("t2_b_ready", b_ready, 1'b1);
    check("t2_a_ready", a_ready, 1'b1);
    check("t2_err_ovf", err_overflow, 1'b0);

    // 3: W, depth 5 -> col 4 dropped
    stream(2'd3, 8'd5, 8'd1, 8'd20, 5);
    check("t3_err_ovf", err_overflow, 1'b1);
    finish_xfer();
    tick();
    check("t3_w_ready", w_ready, 1'b1);
    rd_chk("t3_w00", 2'd3, 2'd0, 2'd0, 8'd20);
    rd_chk("t3_w03", 2'd3, 2'd0, 2'd3, 8'd23);
    rd_chk("t3_w10", 2'd3, 2'd1, 2'd0, 8'd0);

    // 4: FIFO fill, overflow, drain, underflow
    do_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      x_push = 1'b1; x_data = 8'(i + 1);
      tick();
    end
    check("t4_full", x_full, 1'b1);
    check("t4_no_ovf_yet", err_overflow, 1'b0);
    x_data = 8'd99;
    tick();
    x_push = 1'b0;
    check("t4_ovf", err_overflow, 1'b1);
    for (int unsigned i = 0; i < 16; i++) begin
      tensor_ren = 1'b1;
      tick();
      check($sformatf("t4_pop%0d", i), mem_wdata, 8'(i + 1));
    end
    check("t4_empty", x_empty, 1'b1);
    check("t4_no_udf_yet", err_underflow, 1'b0);
    tick();
    tensor_ren = 1'b0;
    check("t4_pop_empty", mem_wdata, 8'd0);
    check("t4_udf", err_underflow, 1'b1);
    x_push = 1'b1; x_data = 8'h55;
    tick();
    x_data = 8'h66; tensor_ren = 1'b1;
    tick();
    x_push = 1'b0;
    check("t4_pp_data", mem_wdata, 8'h55);
    check("t4_pp_not_empty", x_empty, 1'b0);
    tick();
    tensor_ren = 1'b0;
    check("t4_pp_last", mem_wdata, 8'h66);
    check("t4_pp_empty", x_empty, 1'b1);

    // 5: consume during COMMIT of A
    stream(2'd0, 8'd2, 8'd1, 8'd40, 2);
    finish_xfer();
    consume = 3'b001;
    tick();
    check("t5_commit_wins", a_ready, 1'b1);
    tick();
    consume = 3'b000;
    check("t5_consume", a_ready, 1'b0);

    // 6: reset mid-load
    stream(2'd3, 8'd1, 8'd1, 8'd77, 1);
    finish_xfer();
    tick();
    check("t6_w_ready_pre", w_ready, 1'b1);
    stream(2'd0, 8'd2, 8'd2, 8'd50, 2);
    rst = 1'b1;
    #1;
    check("t6_w_ready_rst", w_ready, 1'b0);
    check("t6_a_ready_rst", a_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    rd_chk("t6_a00_cleared", 2'd0, 2'd0, 2'd0, 8'd0);
    stream(2'd0, 8'd2, 8'd2, 8'd7, 4);
    finish_xfer();
    tick();
    check("t6_a_ready", a_ready, 1'b1);
    rd_chk("t6_a00", 2'd0, 2'd0, 2'd0, 8'd7);
    rd_chk("t6_a11", 2'd0, 2'd1, 2'd1, 8'd10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
